wb_bfm_arbiter: RTL and testbench

- Round-robin Wishbone B4 arbiter sharing one slave port between NUM_MASTERS BFM masters or transactors in the multi-master test benches.
- Holds the grant for the whole cycle (cyc asserted), so registered-feedback bursts of any CTI/BTE are never interleaved.
- Optional watchdog terminates a stalled access with err, so a hung slave cannot deadlock the bench.

---
 rtl/wb_bfm_arbiter_if.sv | 63 ++++++
 rtl/wb_bfm_arbiter.sv | 155 +++++++++++++++
 tb/tb_wb_bfm_arbiter.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_bfm_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : wb_bfm_arbiter_if
// Brief    : Bus bundle for the Wishbone BFM arbiter: packed per-master
//            request/response slices plus the shared slave port.
// Revision : 1.0 - initial release
// ============================================================================
interface wb_bfm_arbiter_if #(
    parameter int NUM_MASTERS = 2,
    parameter int aw          = 32,
    parameter int dw          = 32
);
    logic [NUM_MASTERS*aw-1:0]     wbm_adr_i;
    logic [NUM_MASTERS*dw-1:0]     wbm_dat_i;
    logic [NUM_MASTERS*dw/8-1:0]   wbm_sel_i;
    logic [NUM_MASTERS-1:0]        wbm_we_i;
    logic [NUM_MASTERS-1:0]        wbm_cyc_i;
    logic [NUM_MASTERS-1:0]        wbm_stb_i;
    logic [NUM_MASTERS*3-1:0]      wbm_cti_i;
    logic [NUM_MASTERS*2-1:0]      wbm_bte_i;
    logic [NUM_MASTERS*dw-1:0]     wbm_dat_o;
    logic [NUM_MASTERS-1:0]        wbm_ack_o;
    logic [NUM_MASTERS-1:0]        wbm_err_o;
    logic [NUM_MASTERS-1:0]        wbm_rty_o;

    logic [aw-1:0]                 wbs_adr_o;
    logic [dw-1:0]                 wbs_dat_o;
    logic [dw/8-1:0]               wbs_sel_o;
    logic                          wbs_we_o;
    logic                          wbs_cyc_o;
    logic                          wbs_stb_o;
    logic [2:0]                    wbs_cti_o;
    logic [1:0]                    wbs_bte_o;
    logic [dw-1:0]                 wbs_dat_i;
    logic                          wbs_ack_i;
    logic                          wbs_err_i;
    logic                          wbs_rty_i;

    logic [NUM_MASTERS-1:0]        grant_o;

    // Arbiter view: it masters the shared slave port and serves the masters.
    modport master (
        input  wbm_adr_i, wbm_dat_i, wbm_sel_i, wbm_we_i, wbm_cyc_i, wbm_stb_i,
               wbm_cti_i, wbm_bte_i,
        output wbm_dat_o, wbm_ack_o, wbm_err_o, wbm_rty_o,
        output wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_cyc_o, wbs_stb_o,
               wbs_cti_o, wbs_bte_o,
        input  wbs_dat_i, wbs_ack_i, wbs_err_i, wbs_rty_i,
        output grant_o
    );

    // Environment view: requesting masters and the shared slave.
    modport slave (
        output wbm_adr_i, wbm_dat_i, wbm_sel_i, wbm_we_i, wbm_cyc_i, wbm_stb_i,
               wbm_cti_i, wbm_bte_i,
        input  wbm_dat_o, wbm_ack_o, wbm_err_o, wbm_rty_o,
        input  wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_cyc_o, wbs_stb_o,
               wbs_cti_o, wbs_bte_o,
        output wbs_dat_i, wbs_ack_i, wbs_err_i, wbs_rty_i,
        input  grant_o
    );
endinterface
`default_nettype wire

// File: rtl/wb_bfm_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_bfm_arbiter
// Brief    : Round-robin Wishbone B4 arbiter with cycle-long grant hold and an
//            optional watchdog that errors out stalled accesses.
// Revision : 1.0 - initial release
// ============================================================================
module wb_bfm_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int aw          = 32,
    parameter int dw          = 32,
    parameter int TIMEOUT     = 0
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    wb_bfm_arbiter_if.master     bus
);

    localparam int c_iw = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam logic [NUM_MASTERS-1:0] c_one = NUM_MASTERS'(1);
    localparam logic [c_iw-1:0]        c_last_rst = c_iw'(NUM_MASTERS - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t                  r_state;
    logic [NUM_MASTERS-1:0]  r_grant;
    logic [c_iw-1:0]         r_idx;
    logic [c_iw-1:0]         r_last;

    logic [c_iw-1:0]         w_ptr;
    logic [c_iw-1:0]         w_sel;
    logic                    w_found;
    logic                    w_gcyc;
    logic                    w_gstb;
    logic                    w_resp;
    logic                    w_wdt_hit;
    logic                    w_wdt_err;

    function automatic logic [c_iw-1:0] wrap_idx(input logic [c_iw-1:0] p, input int off);
        int s;
        s = int'(p) + off;
        if (s >= NUM_MASTERS) s = s - NUM_MASTERS;
        return c_iw'(s);
    endfunction

    // Search starts just past the pointer; while busy the pointer is the
    // owner being released, so the next owner is chosen in the same cycle.
    always_comb begin
        w_sel   = '0;
        w_found = 1'b0;
        w_ptr   = (r_state == S_BUSY) ? r_idx : r_last;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            if (!w_found && bus.wbm_cyc_i[wrap_idx(w_ptr, i)]) begin
                w_found = 1'b1;
                w_sel   = wrap_idx(w_ptr, i);
            end
        end
    end

    assign w_gcyc = |(r_grant & bus.wbm_cyc_i);
    assign w_gstb = |(r_grant & bus.wbm_stb_i);
    assign w_resp = bus.wbs_ack_i | bus.wbs_err_i | bus.wbs_rty_i;

    always_comb begin
        bus.wbs_adr_o = '0;
        bus.wbs_dat_o = '0;
        bus.wbs_sel_o = '0;
        bus.wbs_we_o  = 1'b0;
        bus.wbs_cti_o = '0;
        bus.wbs_bte_o = '0;
        for (int n = 0; n < NUM_MASTERS; n++) begin
            if (r_grant[n]) begin
                bus.wbs_adr_o = bus.wbm_adr_i[n*aw +: aw];
                bus.wbs_dat_o = bus.wbm_dat_i[n*dw +: dw];
                bus.wbs_sel_o = bus.wbm_sel_i[n*(dw/8) +: (dw/8)];
                bus.wbs_we_o  = bus.wbm_we_i[n];
                bus.wbs_cti_o = bus.wbm_cti_i[n*3 +: 3];
                bus.wbs_bte_o = bus.wbm_bte_i[n*2 +: 2];
            end
        end
    end

    assign bus.wbs_cyc_o = w_gcyc;
    assign bus.wbs_stb_o = w_gstb & ~w_wdt_hit;

    // A genuine slave response in the timeout cycle takes precedence.
    assign w_wdt_err     = w_wdt_hit & ~w_resp;

    assign bus.wbm_dat_o = {NUM_MASTERS{bus.wbs_dat_i}};
    assign bus.wbm_ack_o = r_grant & {NUM_MASTERS{bus.wbs_ack_i}};
    assign bus.wbm_err_o = r_grant & {NUM_MASTERS{bus.wbs_err_i | w_wdt_err}};
    assign bus.wbm_rty_o = r_grant & {NUM_MASTERS{bus.wbs_rty_i}};
    assign bus.grant_o   = r_grant;

    if (TIMEOUT > 0) begin : g_wdt
        localparam int c_ww = $clog2(TIMEOUT + 1);
        localparam logic [c_ww-1:0] c_limit = c_ww'(TIMEOUT);
        logic [c_ww-1:0] r_wdt;

        assign w_wdt_hit = w_gcyc & w_gstb & (r_wdt == c_limit);

        always_ff @(posedge wb_clk_i) begin
            if (!wb_rst_i) begin
                r_wdt <= '0;
            end else if (!(w_gcyc & w_gstb) || w_resp || w_wdt_hit) begin
                r_wdt <= '0;
            end else begin
                r_wdt <= r_wdt + 1'b1;
            end
        end
    end else begin : g_no_wdt
        assign w_wdt_hit = 1'b0;
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_idx   <= '0;
            r_last  <= c_last_rst;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_grant <= c_one << w_sel;
                        r_idx   <= w_sel;
                        r_state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    // Ownership only moves once the owner has dropped cyc.
                    if (!w_gcyc) begin
                        r_last <= r_idx;
                        if (w_found) begin
                            r_grant <= c_one << w_sel;
                            r_idx   <= w_sel;
                        end else begin
                            r_grant <= '0;
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_grant <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_bfm_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_bfm_arbiter
// Brief    : Self-checking bench for wb_bfm_arbiter (2 masters, TIMEOUT=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_bfm_arbiter;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic auto_ack = 1'b0;
    logic man_ack = 1'b0;

    always #5 clk = ~clk;

    wb_bfm_arbiter_if #(.NUM_MASTERS(N), .aw(AW), .dw(DW)) bus ();

    wb_bfm_arbiter #(.NUM_MASTERS(N), .aw(AW), .dw(DW), .TIMEOUT(TO)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst_n),
        .bus      (bus)
    );

    assign bus.wbs_ack_i = auto_ack ? (bus.wbs_cyc_o & bus.wbs_stb_o) : man_ack;
    assign bus.wbs_err_i = 1'b0;
    assign bus.wbs_rty_i = 1'b0;
    assign bus.wbs_dat_i = 32'hCAFE_F00D;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_m(input int m, input logic cyc, input logic stb, input logic [2:0] cti);
        bus.wbm_cyc_i[m]       = cyc;
        bus.wbm_stb_i[m]       = stb;
        bus.wbm_cti_i[m*3 +: 3] = cti;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        rst_n = 1'b0;
        auto_ack = 1'b0;
        man_ack = 1'b0;
        set_m(0, 1'b0, 1'b0, 3'b000);
        set_m(1, 1'b0, 1'b0, 3'b000);
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic        rst_n;
        logic [1:0]  cyc;
        logic        ack;
        logic [1:0]  e_grant;
        logic        e_scyc;
        logic        e_sstb;
        logic [1:0]  e_ack;
        logic [31:0] e_adr;
    } vec_t;

    typedef struct {
        logic [1:0] ack;
        logic [2:0] cti;
    } beat_t;

    vec_t  vecs[19];
    int    sb[$];
    beat_t bsb[$];

    initial begin
        #200000;
        $display("FAIL global_timeout: got stuck, expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [1:0] a;
        logic [1:0] e;
        int done[2];
        int beats;
        logic m1_done;
        beat_t bt;

        bus.wbm_adr_i = {32'h0000_0100, 32'h0000_0200};
        bus.wbm_dat_i = {32'h1111_1111, 32'h0000_0000};
        bus.wbm_sel_i = '1;
        bus.wbm_we_i  = '1;
        bus.wbm_cyc_i = '0;
        bus.wbm_stb_i = '0;
        bus.wbm_cti_i = '0;
        bus.wbm_bte_i = '0;

        //             rst cyc   ack  grant scyc sstb ack    adr
        vecs[0]  = '{1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 32'h0};
        vecs[1]  = '{1'b1, 2'b10, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 32'h0};
        vecs[2]  = '{1'b1, 2'b10, 1'b1, 2'b10, 1'b1, 1'b1, 2'b10, 32'h100};
        vecs[3]  = '{1'b1, 2'b00, 1'b0, 2'b10, 1'b0, 1'b0, 2'b00, 32'h100};
        vecs[4]  = '{1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 32'h0};
        vecs[5]  = '{1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 32'h0};
        vecs[6]  = '{1'b1, 2'b11, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 32'h0};
        vecs[7]  = '{1'b1, 2'b11, 1'b1, 2'b01, 1'b1, 1'b1, 2'b01, 32'h200};
        vecs[8]  = '{1'b1, 2'b10, 1'b0, 2'b01, 1'b0, 1'b0, 2'b00, 32'h200};
        vecs[9]  = '{1'b1, 2'b10, 1'b1, 2'b10, 1'b1, 1'b1, 2'b10, 32'h100};
        vecs[10] = '{1'b1, 2'b00, 1'b0, 2'b10, 1'b0, 1'b0, 2'b00, 32'h100};
        vecs[11] = '{1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 32'h0};
        vecs[12] = '{1'b1, 2'b10, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 32'h0};
        vecs[13] = '{1'b1, 2'b10, 1'b1, 2'b10, 1'b1, 1'b1, 2'b10, 32'h100};
        vecs[14] = '{1'b0, 2'b11, 1'b0, 2'b10, 1'b1, 1'b1, 2'b00, 32'h100};
        vecs[15] = '{1'b1, 2'b11, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 32'h0};
        vecs[16] = '{1'b1, 2'b11, 1'b1, 2'b01, 1'b1, 1'b1, 2'b01, 32'h200};
        vecs[17] = '{1'b1, 2'b00, 1'b0, 2'b01, 1'b0, 1'b0, 2'b00, 32'h200};
        vecs[18] = '{1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 32'h0};

        do_reset();
        @(negedge clk);
        check("reset_grant", 64'(bus.grant_o), 64'h0);
        check("reset_scyc", 64'({bus.wbs_cyc_o, bus.wbs_stb_o}), 64'h0);
        check("reset_resp", 64'({bus.wbm_ack_o, bus.wbm_err_o, bus.wbm_rty_o}), 64'h0);

        // Cycle-by-cycle vectors: single write, simultaneous request, reset mid-access.
        for (int v = 0; v < 19; v++) begin
            tick();
            rst_n = vecs[v].rst_n;
            set_m(0, vecs[v].cyc[0], vecs[v].cyc[0], 3'b000);
            set_m(1, vecs[v].cyc[1], vecs[v].cyc[1], 3'b000);
            man_ack = vecs[v].ack;
            @(negedge clk);
            check($sformatf("v%0d_grant", v), 64'(bus.grant_o), 64'(vecs[v].e_grant));
            check($sformatf("v%0d_scyc", v), 64'(bus.wbs_cyc_o), 64'(vecs[v].e_scyc));
            check($sformatf("v%0d_sstb", v), 64'(bus.wbs_stb_o), 64'(vecs[v].e_sstb));
            check($sformatf("v%0d_ack", v), 64'(bus.wbm_ack_o), 64'(vecs[v].e_ack));
            check($sformatf("v%0d_err", v), 64'(bus.wbm_err_o), 64'h0);
            check($sformatf("v%0d_adr", v), 64'(bus.wbs_adr_o), 64'(vecs[v].e_adr));
        end

        // Both masters stream 10 single accesses each; grants must alternate.
        do_reset();
        auto_ack = 1'b1;
        for (int i = 0; i < 20; i++) sb.push_back(i % 2);
        done[0] = 0;
        done[1] = 0;
        set_m(0, 1'b1, 1'b1, 3'b000);
        set_m(1, 1'b1, 1'b1, 3'b000);
        for (int cy = 0; cy < 300 && (done[0] < 10 || done[1] < 10); cy++) begin
            @(negedge clk);
            a = bus.wbm_ack_o;
            if (a != 2'b00) begin
                if (sb.size() == 0) begin
                    check("alt_extra_ack", 64'(a), 64'h0);
                end else begin
                    e = 2'b01 << sb.pop_front();
                    check("alt_ack", 64'(a), 64'(e));
                end
            end
            tick();
            for (int m = 0; m < 2; m++) begin
                if (a[m]) begin
                    done[m]++;
                    set_m(m, 1'b0, 1'b0, 3'b000);
                end else if (done[m] < 10) begin
                    set_m(m, 1'b1, 1'b1, 3'b000);
                end
            end
        end
        check("alt_done0", 64'(done[0]), 64'd10);
        check("alt_done1", 64'(done[1]), 64'd10);
        check("alt_sb_left", 64'(sb.size()), 64'd0);
        set_m(0, 1'b0, 1'b0, 3'b000);
        set_m(1, 1'b0, 1'b0, 3'b000);

        // 4-beat incrementing burst on master 0 while master 1 waits.
        do_reset();
        auto_ack = 1'b1;
        for (int i = 0; i < 3; i++) bsb.push_back('{2'b01, 3'b010});
        bsb.push_back('{2'b01, 3'b111});
        bsb.push_back('{2'b10, 3'b000});
        beats = 0;
        m1_done = 1'b0;
        set_m(0, 1'b1, 1'b1, 3'b010);
        set_m(1, 1'b1, 1'b1, 3'b000);
        for (int cy = 0; cy < 100 && !m1_done; cy++) begin
            @(negedge clk);
            a = bus.wbm_ack_o;
            if (a != 2'b00) begin
                if (bsb.size() == 0) begin
                    check("burst_extra_ack", 64'(a), 64'h0);
                end else begin
                    bt = bsb.pop_front();
                    check("burst_ack_cti", 64'({a, bus.wbs_cti_o}), 64'({bt.ack, bt.cti}));
                end
            end
            tick();
            if (a[0]) begin
                beats++;
                if (beats == 4) set_m(0, 1'b0, 1'b0, 3'b000);
                else if (beats == 3) set_m(0, 1'b1, 1'b1, 3'b111);
            end
            if (a[1]) begin
                set_m(1, 1'b0, 1'b0, 3'b000);
                m1_done = 1'b1;
            end
        end
        check("burst_sb_left", 64'(bsb.size()), 64'd0);
        check("burst_m1_done", 64'(m1_done), 64'd1);

        // Watchdog: slave never answers, err after TIMEOUT stalled cycles.
        do_reset();
        tick();
        set_m(0, 1'b1, 1'b1, 3'b000);
        tick();
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check($sformatf("wdt_c%0d_err_stb", i), 64'({bus.wbm_err_o, bus.wbs_stb_o}),
                  (i == TO) ? 64'b010 : 64'b001);
            tick();
        end
        set_m(0, 1'b0, 1'b0, 3'b000);
        tick();
        set_m(0, 1'b1, 1'b1, 3'b000);
        tick();
        for (int i = 0; i <= TO; i++) begin
            if (i == TO) man_ack = 1'b1;
            @(negedge clk);
            if (i == TO) begin
                check("wdt_tie_ack", 64'(bus.wbm_ack_o), 64'b01);
                check("wdt_tie_err", 64'(bus.wbm_err_o), 64'b00);
            end
            tick();
        end
        man_ack = 1'b0;
        set_m(0, 1'b0, 1'b0, 3'b000);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
